// File: rtl/key_event_gen_pkg.sv
// Shared definitions for the debounced-key event generator.
// State encoding and default timing constants used by RTL and bench.
package key_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/key_event_gen.sv
// Turns a debounced button level into one-cycle press/release/short/
// long/repeat events plus a registered held level.
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic repeat_en,
    output logic press,
    output logic key_release,
    output logic short_press,
    output logic long_press,
    output logic key_repeat,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n, short_n;
    logic             long_n, repeat_n, held_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            key_repeat  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            press       <= press_n;
            key_release <= release_n;
            short_press <= short_n;
            long_press  <= long_n;
            key_repeat  <= repeat_n;
            held        <= held_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        short_n   = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (btn) begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end
            end
            ST_HOLD: begin
                // release has priority over reaching the long threshold
                if (!btn) begin
                    state_n   = ST_IDLE;
                    release_n = 1'b1;
                    short_n   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_n = ST_LONG;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (!btn) begin
                    state_n   = ST_IDLE;
                    release_n = 1'b1;
                end else if (repeat_en && cnt == REP_LAST) begin
                    repeat_n = 1'b1;
                    cnt_n    = '0;
                end else if (cnt != REP_LAST) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        held_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed timing scenarios plus random
// button traffic checked every cycle against an event-age model.
module tb_key_event_gen;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic repeat_en = 1'b0;
    logic press, key_release, short_press;
    logic long_press, key_repeat, held;

    int checks = 0;
    int failures = 0;

    key_event_gen #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .repeat_en  (repeat_en),
        .press      (press),
        .key_release(key_release),
        .short_press(short_press),
        .long_press (long_press),
        .key_repeat (key_repeat),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: tracks age since press and the age of the last long/repeat
    // event; outputs {press, release, short, long, repeat, held}.
    logic       m_pressed = 1'b0;
    logic       m_long = 1'b0;
    int         m_age = 0;
    int         m_last = 0;
    logic [5:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pressed <= 1'b0;
            m_long    <= 1'b0;
            m_age     <= 0;
            m_last    <= 0;
            m_out     <= '0;
        end else begin
            automatic logic       p = m_pressed;
            automatic logic       lg = m_long;
            automatic int         age = m_age;
            automatic int         last = m_last;
            automatic logic [5:0] o = '0;
            if (!p) begin
                if (btn) begin
                    p = 1'b1; lg = 1'b0; age = 0; o[5] = 1'b1;
                end
            end else if (!btn) begin
                p = 1'b0; o[4] = 1'b1; o[3] = !lg;
            end else begin
                age++;
                if (!lg) begin
                    if (age == LONG) begin
                        lg = 1'b1; last = age; o[2] = 1'b1;
                    end
                end else if (repeat_en && (age - last) >= REP) begin
                    last = age; o[1] = 1'b1;
                end
            end
            o[0] = p;
            m_pressed <= p;
            m_long    <= lg;
            m_age     <= age;
            m_last    <= last;
            m_out     <= o;
        end
    end

    always @(negedge clk) begin
        check("outputs", {press, key_release, short_press,
                          long_press, key_repeat, held}, m_out);
        check("press_excl", press & (key_release | short_press |
                                     long_press | key_repeat), 0);
        check("long_rpt_excl", long_press & key_repeat, 0);
    end

    int p_at, l_at, rel_at, sh_at, held_cyc, rel_cnt;
    int rpt_q[$];

    // Starts and ends on a negedge; offset 0 is the cycle press shows.
    task automatic hold_btn(input int n, input int en_at);
        p_at = -1; l_at = -1; rel_at = -1; sh_at = -1; held_cyc = 0;
        rpt_q.delete();
        for (int i = 0; i < n + 3; i++) begin
            btn = (i < n);
            repeat_en = (i >= en_at);
            @(posedge clk);
            @(negedge clk);
            if (press) p_at = i;
            if (long_press) l_at = i;
            if (key_release) rel_at = i;
            if (short_press) sh_at = i;
            if (key_repeat) rpt_q.push_back(i);
            if (held) held_cyc++;
        end
    endtask

    int len;

    initial begin
        btn = 1'b1;
        repeat_en = 1'b1;
        #1;
        check("rst_outs", {press, key_release, short_press,
                           long_press, key_repeat, held}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_press", press, 1);
        check("rst_held", held, 1);
        repeat (3) @(negedge clk);
        check("rst_held_c4", held, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midhold_rst", {press, key_release, short_press,
                              long_press, key_repeat, held}, 0);
        repeat (2) @(negedge clk);
        btn = 1'b0;
        rst_n = 1'b1;
        rel_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (key_release || short_press) rel_cnt++;
        end
        check("no_rel_after_rst", rel_cnt, 0);

        hold_btn(3, 0);
        check("s3_press", p_at, 0);
        check("s3_release", rel_at, 3);
        check("s3_short", sh_at, 3);
        check("s3_long", l_at, -1);

        hold_btn(20, 0);
        check("l20_press", p_at, 0);
        check("l20_long", l_at, 8);
        check("l20_nrpt", rpt_q.size(), 2);
        check("l20_rpt0", rpt_q.size() > 0 ? rpt_q[0] : -1, 12);
        check("l20_rpt1", rpt_q.size() > 1 ? rpt_q[1] : -1, 16);
        check("l20_release", rel_at, 20);
        check("l20_short", sh_at, -1);

        hold_btn(8, 0);
        check("edge_release", rel_at, 8);
        check("edge_short", sh_at, 8);
        check("edge_long", l_at, -1);

        hold_btn(28, 18);
        check("dis_long", l_at, 8);
        check("dis_nrpt", rpt_q.size(), 3);
        check("dis_rpt0", rpt_q.size() > 0 ? rpt_q[0] : -1, 18);
        check("dis_rpt1", rpt_q.size() > 1 ? rpt_q[1] : -1, 22);
        check("dis_rpt2", rpt_q.size() > 2 ? rpt_q[2] : -1, 26);
        check("dis_release", rel_at, 28);

        hold_btn(1, 0);
        check("gl_press", p_at, 0);
        check("gl_release", rel_at, 1);
        check("gl_short", sh_at, 1);
        check("gl_held", held_cyc, 1);

        for (int s = 0; s < 300; s++) begin
            len = (s % 2 == 0) ? $urandom_range(1, 30)
                               : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                btn = (s % 2 == 0);
                if ($urandom_range(0, 7) == 0) repeat_en = ~repeat_en;
                @(negedge clk);
            end
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        btn = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
